commu_m_bufrd: RTL
==================

// Module: commu_m_bufrd
// PURPOSE
//  ARM-facing package buffer and serial read port for the master-FPGA commu path.
//  Stores complete packages from the repacker and reports the count on cnt_pkg_buf.
//  That count drives the ARM interrupt logic. The ARM frames a read with buf_frm and
//  clocks the oldest package out serially on buf_sclk/buf_sdo. A package is popped
//  only after a complete read.
// PARAMETERS
//  PKG_BYTES  16  bytes per package; fixed length
//  PKG_DEPTH  8   package slots; must be 2..15 (4-bit count)
//  SLOT_AW    3   log2(PKG_DEPTH)
//  BYTE_AW    4   log2(PKG_BYTES)
// PORTS
//  clk_sys      in   1  system clock
//  rst_n        in   1  reset, asynchronous, active-low
//  repk_frm     in   1  repacker frame; high while a package is written (clk_sys domain)
//  wr_vld       in   1  byte strobe, qualified by repk_frm
//  wr_dat       in   8  package byte
//  buf_frm      in   1  ARM read frame; async, 2FF-synced internally
//  buf_sclk     in   1  ARM shift clock; async, 2FF-synced; rising edge advances one bit
//  buf_sdo      out  1  serial data to ARM, MSB first, byte 0 first
//  cnt_pkg_buf  out  4  committed packages held
//  ovf          out  1  sticky: a package was dropped (buffer full or wrong length)
//  wd_arm_high  in   1  ARM-watchdog flush pulse; port exists only with COMMU_WD_FLUSH_EN
// BEHAVIOUR
//  Reset: cnt_pkg_buf=0, buf_sdo=0, ovf=0, all pointers=0, both FSMs idle.
//  Edges: repk_frm uses 1 register for edge detect.
//  Edges: buf_frm and buf_sclk each use a 2FF sync plus 1 edge register.
//    The ARM sees 3-4 clk_sys cycles of latency, so its sclk half-period must be >= 4 clk_sys.
//  Write FSM (W_IDLE, W_FILL, W_COMMIT):
//    W_IDLE -> W_FILL on repk_frm rising; byte index := 0.
//    W_FILL: each wr_vld writes mem[wr_slot][idx] and idx++.
//    W_FILL: bytes beyond PKG_BYTES are ignored and flag the package as bad.
//    W_FILL -> W_COMMIT on repk_frm falling.
//    W_COMMIT (1 cycle): if the package is good (exactly PKG_BYTES bytes) and not full,
//      wr_slot++ (mod PKG_DEPTH) and cnt++.
//    W_COMMIT: otherwise the package is discarded, wr_slot is unchanged and ovf:=1.
//    Full means cnt==PKG_DEPTH with no pop in the same cycle. A pop in the same cycle frees the slot.
//    Then -> W_IDLE.
//  Read FSM (R_IDLE, R_LOAD, R_SHIFT, R_DONE):
//    R_IDLE: on buf_frm rising with cnt>0 -> R_LOAD. With cnt==0 stay idle; buf_sdo stays 0.
//    R_LOAD: 1-cycle memory latency; shreg := mem[rd_slot][0]; buf_sdo := bit7; bit counter := 0.
//    R_SHIFT: each sclk rising shifts shreg left, bit counter++.
//    R_SHIFT: after 8 bits, load the next byte on the same edge.
//    R_SHIFT: after PKG_BYTES*8 edges -> R_DONE; buf_sdo := 0.
//    R_DONE: on buf_frm falling, pop: rd_slot++, cnt-- -> R_IDLE.
//    Abort: buf_frm falling in R_LOAD or R_SHIFT -> R_IDLE with no pop.
//      The same package is re-read from byte 0 on the next frame.
//    Extra sclk edges in R_DONE are ignored.
//  Simultaneous commit and pop: cnt is unchanged; both pointers advance.
//  Counts and pointers wrap mod PKG_DEPTH; the cnt width never overflows (cnt<=PKG_DEPTH<=15).
//  Memory: PKG_DEPTH*PKG_BYTES x 8 simple dual-port RAM, 1-cycle registered read.
// CONFIGURATION
//  COMMU_WD_FLUSH_EN defined:
//    wd_arm_high port present.
//    A 1-cycle wd_arm_high pulse sets rd_slot:=wr_slot, cnt:=0 and read FSM -> R_IDLE, buf_sdo:=0.
//    The flush does not affect a package in W_FILL.
//    Flush and commit in the same cycle: flush applies first, so cnt=1 afterwards.
//  COMMU_WD_FLUSH_EN undefined:
//    No port; packages are dropped only on overflow.
// TESTING
//  1 Write 1 package of bytes 0x00..0x0F.
//    -> cnt=1 two cycles after repk_frm falls.
//    -> Frame read of 128 sclk edges yields 0x00,0x01..0x0F MSB first.
//    -> buf_frm fall -> cnt=0.
//  2 Write 9 good packages with no reads (DEPTH=8).
//    -> cnt=8 and ovf=1.
//    -> 8 reads return packages 1..8; package 9 is absent.
//  3 Read frame dropped after 40 sclk edges.
//    -> cnt unchanged.
//    -> Next frame returns the same package from byte 0.
//  4 Package of 15 bytes, then one of 17 bytes.
//    -> Both discarded; cnt=0; ovf=1.
//  5 Commit lands on the same clk as a pop, with cnt=8.
//    -> Commit accepted; cnt stays 8; ovf stays 0.
//  6 (COMMU_WD_FLUSH_EN) 3 packages buffered and a read in R_SHIFT, then wd_arm_high pulse.
//    -> cnt=0 next cycle; buf_sdo=0; read FSM idle.
//    -> A new package then reads back correctly.

Source files
------------

// File: rtl/commu_m_bufrd.sv
// commu_m_bufrd: ARM-facing package buffer with framed serial read port.
// Define COMMU_WD_FLUSH_EN to add the wd_arm_high watchdog flush input.
module commu_m_bufrd #(
  parameter int PKG_BYTES = 16,
  parameter int PKG_DEPTH = 8,
  parameter int SLOT_AW   = 3,
  parameter int BYTE_AW   = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       repk_frm,
  input  logic       wr_vld,
  input  logic [7:0] wr_dat,
  input  logic       buf_frm,
  input  logic       buf_sclk,
  output logic       buf_sdo,
  output logic [3:0] cnt_pkg_buf,
  output logic       ovf
`ifdef COMMU_WD_FLUSH_EN
  ,
  input  logic       wd_arm_high
`endif
);

  localparam int AW = SLOT_AW + BYTE_AW;
  localparam logic [3:0] DEPTH4 = 4'(PKG_DEPTH);
  localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(PKG_DEPTH - 1);
  localparam logic [BYTE_AW:0] NBYTES = (BYTE_AW + 1)'(PKG_BYTES);
  localparam logic [BYTE_AW:0] IDX_ONE = (BYTE_AW + 1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_COMMIT} wr_st_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SHIFT, R_DONE} rd_st_t;

  wr_st_t wr_st;
  rd_st_t rd_st;

  logic       repk_q;
  logic [1:0] frm_s;
  logic       frm_q;
  logic [1:0] sclk_s;
  logic       sclk_q;

  logic [SLOT_AW-1:0] wr_slot;
  logic [SLOT_AW-1:0] rd_slot;
  logic [BYTE_AW:0]   w_idx;
  logic               w_bad;
  logic [BYTE_AW:0]   rd_byte;
  logic [2:0]         bit_cnt;
  logic [6:0]         shreg;
  logic [7:0]         rd_q;
  logic [3:0]         cnt;

  logic [7:0] mem [PKG_DEPTH*PKG_BYTES];

  logic repk_rise, repk_fall;
  logic frm_rise, frm_fall, sclk_rise;
  logic flush, pop, full, blocked;
  logic idx_full, good, commit_ok, we;
  logic [AW-1:0] wa, ra;

`ifdef COMMU_WD_FLUSH_EN
  assign flush = wd_arm_high;
`else
  assign flush = 1'b0;
`endif

  function automatic logic [SLOT_AW-1:0] nxt_slot(
    input logic [SLOT_AW-1:0] s
  );
    return (s == LAST_SLOT) ? '0 : s + SLOT_AW'(1);
  endfunction

  assign repk_rise = repk_frm & ~repk_q;
  assign repk_fall = ~repk_frm & repk_q;
  assign frm_rise  = frm_s[1] & ~frm_q;
  assign frm_fall  = ~frm_s[1] & frm_q;
  assign sclk_rise = sclk_s[1] & ~sclk_q;

  assign pop  = (rd_st == R_DONE) && frm_fall && !flush;
  assign full = (cnt == DEPTH4) && !pop && !flush;

  // Full buffer: wr_slot aliases the oldest package, keep it intact
  assign blocked = (cnt == DEPTH4) && (rd_st != R_DONE) && !flush;

  assign idx_full  = (w_idx == NBYTES);
  assign good      = idx_full && !w_bad;
  assign commit_ok = (wr_st == W_COMMIT) && good && !full;

  assign we = (wr_st == W_FILL) && repk_frm && wr_vld
            && !idx_full && !blocked;
  assign wa = {wr_slot, w_idx[BYTE_AW-1:0]};
  assign ra = {rd_slot, rd_byte[BYTE_AW-1:0]};

  assign cnt_pkg_buf = cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      repk_q <= 1'b0;
      frm_s  <= '0;
      frm_q  <= 1'b0;
      sclk_s <= '0;
      sclk_q <= 1'b0;
    end else begin
      repk_q <= repk_frm;
      frm_s  <= {frm_s[0], buf_frm};
      frm_q  <= frm_s[1];
      sclk_s <= {sclk_s[0], buf_sclk};
      sclk_q <= sclk_s[1];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (we) mem[wa] <= wr_dat;
    rd_q <= mem[ra];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_st   <= W_IDLE;
      wr_slot <= '0;
      w_idx   <= '0;
      w_bad   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (wr_st)
        W_IDLE: begin
          if (repk_rise) begin
            wr_st <= W_FILL;
            w_idx <= '0;
            w_bad <= 1'b0;
          end
        end
        W_FILL: begin
          if (repk_frm && wr_vld) begin
            if (idx_full || blocked) w_bad <= 1'b1;
            if (!idx_full) w_idx <= w_idx + IDX_ONE;
          end
          if (repk_fall) wr_st <= W_COMMIT;
        end
        W_COMMIT: begin
          wr_st <= W_IDLE;
          if (commit_ok) wr_slot <= nxt_slot(wr_slot);
          else ovf <= 1'b1;
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_st   <= R_IDLE;
      rd_slot <= '0;
      rd_byte <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      buf_sdo <= 1'b0;
    end else if (flush) begin
      rd_st   <= R_IDLE;
      rd_slot <= wr_slot;
      rd_byte <= '0;
      buf_sdo <= 1'b0;
    end else begin
      case (rd_st)
        R_IDLE: begin
          rd_byte <= '0;
          if (frm_rise && cnt != 4'd0) rd_st <= R_LOAD;
        end
        R_LOAD: begin
          if (frm_fall) begin
            rd_st <= R_IDLE;
          end else begin
            rd_st   <= R_SHIFT;
            shreg   <= rd_q[6:0];
            buf_sdo <= rd_q[7];
            bit_cnt <= '0;
            rd_byte <= IDX_ONE;
          end
        end
        R_SHIFT: begin
          if (frm_fall) begin
            rd_st   <= R_IDLE;
            rd_byte <= '0;
            buf_sdo <= 1'b0;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              shreg   <= {shreg[5:0], 1'b0};
              buf_sdo <= shreg[6];
            end else if (rd_byte == NBYTES) begin
              rd_st   <= R_DONE;
              buf_sdo <= 1'b0;
            end else begin
              shreg   <= rd_q[6:0];
              buf_sdo <= rd_q[7];
              rd_byte <= rd_byte + IDX_ONE;
            end
          end
        end
        R_DONE: begin
          if (frm_fall) begin
            rd_st   <= R_IDLE;
            rd_slot <= nxt_slot(rd_slot);
            rd_byte <= '0;
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (flush) cnt <= {3'b0, commit_ok};
    else cnt <= cnt + {3'b0, commit_ok} - {3'b0, pop};
  end

endmodule
